// File: rtl/switch_alloc_dsb_if.sv
// Handshake bundle between the DSB header decoders, the switch allocator and the crossbar.
// The master side drives requests and tail transfers. The slave (allocator) side drives the grant state.
interface switch_alloc_dsb_if;
  logic [24:0] req_vec;
  logic [4:0]  tail_xfer;
  logic [24:0] grant;
  logic [14:0] in_sel;
  logic [4:0]  out_busy;
  logic [4:0]  in_granted;

  modport master (
    output req_vec, tail_xfer,
    input  grant, in_sel, out_busy, in_granted
  );

  modport slave (
    input  req_vec, tail_xfer,
    output grant, in_sel, out_busy, in_granted
  );
endinterface

// File: rtl/switch_alloc_dsb.sv
// Packet-level round-robin switch allocator for the 5-port DSB router.
// Each output is locked to one input from its HEAD grant until that input's TAIL crosses the crossbar.
module switch_alloc_dsb (
  input  logic              clk,
  input  logic              rst,
  switch_alloc_dsb_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t      state     [5];
  state_t      state_nxt [5];
  logic [2:0]  ptr       [5];
  logic [2:0]  ptr_nxt   [5];
  logic [4:0]  cand      [5];
  logic [2:0]  pick      [5];

  logic [24:0] grant_p0,      grant_nxt;
  logic [14:0] in_sel_p0,     in_sel_nxt;
  logic [4:0]  out_busy_p0,   out_busy_nxt;
  logic [4:0]  in_granted_p0, in_granted_nxt;

  function automatic logic [2:0] wrap_inc(input logic [2:0] v);
    return (v == 3'd4) ? 3'd0 : v + 3'd1;
  endfunction

  // First set bit of cand scanning from start with modulo-5 wrap; only used when cand is non-empty.
  function automatic logic [2:0] rr_pick(input logic [4:0] c, input logic [2:0] start);
    logic [2:0] idx;
    logic [2:0] sel;
    logic       found;
    idx   = start;
    sel   = start;
    found = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (!found && c[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
      idx = wrap_inc(idx);
    end
    return sel;
  endfunction

  // Inputs already holding an output are masked: the decoder keeps requesting until the head is popped.
  always_comb begin
    for (int o = 0; o < 5; o++) begin
      cand[o] = '0;
      for (int i = 0; i < 5; i++) begin
        cand[o][i] = bus.req_vec[5*i + o] & ~in_granted_p0[i];
      end
      pick[o] = rr_pick(cand[o], ptr[o]);
    end
  end

  always_comb begin
    grant_nxt    = grant_p0;
    in_sel_nxt   = in_sel_p0;
    out_busy_nxt = out_busy_p0;
    for (int o = 0; o < 5; o++) begin
      state_nxt[o] = state[o];
      ptr_nxt[o]   = ptr[o];
    end
    for (int o = 0; o < 5; o++) begin
      case (state[o])
        IDLE: begin
          if (|cand[o]) begin
            grant_nxt[5*o + int'(pick[o])] = 1'b1;
            in_sel_nxt[3*o +: 3]           = pick[o];
            out_busy_nxt[o]                = 1'b1;
            state_nxt[o]                   = LOCKED;
            ptr_nxt[o]                     = wrap_inc(pick[o]);
          end
        end
        LOCKED: begin
          if (bus.tail_xfer[in_sel_p0[3*o +: 3]]) begin
            grant_nxt[5*o +: 5]  = '0;
            in_sel_nxt[3*o +: 3] = '0;
            out_busy_nxt[o]      = 1'b0;
            state_nxt[o]         = IDLE;
          end
        end
      endcase
    end
    in_granted_nxt = '0;
    for (int o = 0; o < 5; o++) begin
      for (int i = 0; i < 5; i++) begin
        in_granted_nxt[i] = in_granted_nxt[i] | grant_nxt[5*o + i];
      end
    end
  end

  // Stage p0: every crossbar-facing output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < 5; o++) begin
        state[o] <= IDLE;
        ptr[o]   <= 3'd0;
      end
      grant_p0      <= '0;
      in_sel_p0     <= '0;
      out_busy_p0   <= '0;
      in_granted_p0 <= '0;
    end else begin
      for (int o = 0; o < 5; o++) begin
        state[o] <= state_nxt[o];
        ptr[o]   <= ptr_nxt[o];
      end
      grant_p0      <= grant_nxt;
      in_sel_p0     <= in_sel_nxt;
      out_busy_p0   <= out_busy_nxt;
      in_granted_p0 <= in_granted_nxt;
    end
  end

  assign bus.grant      = grant_p0;
  assign bus.in_sel     = in_sel_p0;
  assign bus.out_busy   = out_busy_p0;
  assign bus.in_granted = in_granted_p0;
endmodule

// File: tb/tb_switch_alloc_dsb.sv
// Directed self-checking bench for switch_alloc_dsb.
// Inputs change 1 time unit after each rising edge, and outputs are sampled at that same point.
module tb_switch_alloc_dsb;
  logic clk;
  logic rst;
  int   checks;
  int   fails;

  switch_alloc_dsb_if bus ();

  switch_alloc_dsb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_vec   = '0;
    bus.tail_xfer = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.grant !== 25'd0) begin
      fails++; $display("FAIL reset_grant got=%h want=%h", bus.grant, 25'd0);
    end
    checks++;
    if (bus.in_sel !== 15'd0) begin
      fails++; $display("FAIL reset_in_sel got=%h want=%h", bus.in_sel, 15'd0);
    end
    checks++;
    if (bus.out_busy !== 5'd0) begin
      fails++; $display("FAIL reset_out_busy got=%b want=%b", bus.out_busy, 5'd0);
    end
    checks++;
    if (bus.in_granted !== 5'd0) begin
      fails++; $display("FAIL reset_in_granted got=%b want=%b", bus.in_granted, 5'd0);
    end
  endtask

  task automatic test_single();
    logic [24:0] exp_g;
    do_reset();
    bus.req_vec    = '0;
    bus.req_vec[8] = 1'b1;
    tick();
    exp_g = '0; exp_g[16] = 1'b1;
    checks++;
    if (bus.grant !== exp_g) begin
      fails++; $display("FAIL single_grant got=%h want=%h", bus.grant, exp_g);
    end
    checks++;
    if (bus.in_sel !== 15'h0200) begin
      fails++; $display("FAIL single_in_sel got=%h want=%h", bus.in_sel, 15'h0200);
    end
    checks++;
    if (bus.out_busy !== 5'b01000) begin
      fails++; $display("FAIL single_out_busy got=%b want=%b", bus.out_busy, 5'b01000);
    end
    checks++;
    if (bus.in_granted !== 5'b00010) begin
      fails++; $display("FAIL single_in_granted got=%b want=%b", bus.in_granted, 5'b00010);
    end
    bus.req_vec   = '0;
    bus.tail_xfer = 5'b00010;
    tick();
    bus.tail_xfer = '0;
    checks++;
    if (bus.grant !== 25'd0 || bus.out_busy !== 5'd0 || bus.in_sel !== 15'd0) begin
      fails++; $display("FAIL single_release got=%h/%b/%h want=0/0/0", bus.grant, bus.out_busy, bus.in_sel);
    end
  endtask

  task automatic test_fairness();
    int          order [4];
    logic [24:0] exp_g;
    logic [14:0] exp_s;
    order[0] = 0; order[1] = 2; order[2] = 4; order[3] = 0;
    do_reset();
    bus.req_vec     = '0;
    bus.req_vec[4]  = 1'b1;
    bus.req_vec[14] = 1'b1;
    bus.req_vec[24] = 1'b1;
    tick();
    for (int n = 0; n < 4; n++) begin
      exp_g = '0; exp_g[20 + order[n]] = 1'b1;
      exp_s = '0; exp_s[14:12] = 3'(order[n]);
      checks++;
      if (bus.grant !== exp_g || bus.in_sel !== exp_s) begin
        fails++; $display("FAIL fair_owner%0d got=%h/%h want=%h/%h", n, bus.grant, bus.in_sel, exp_g, exp_s);
      end
      tick();
      tick();
      checks++;
      if (bus.grant !== exp_g) begin
        fails++; $display("FAIL fair_hold%0d got=%h want=%h", n, bus.grant, exp_g);
      end
      bus.tail_xfer = '0;
      bus.tail_xfer[order[n]] = 1'b1;
      tick();
      bus.tail_xfer = '0;
      checks++;
      if (bus.grant !== 25'd0 || bus.out_busy !== 5'd0) begin
        fails++; $display("FAIL fair_bubble%0d got=%h/%b want=0/0", n, bus.grant, bus.out_busy);
      end
      tick();
    end
    bus.req_vec = '0;
  endtask

  task automatic test_lock_hold();
    logic [24:0] exp_g;
    do_reset();
    bus.req_vec     = '0;
    bus.req_vec[12] = 1'b1;
    tick();
    exp_g = '0; exp_g[12] = 1'b1;
    checks++;
    if (bus.grant !== exp_g) begin
      fails++; $display("FAIL hold_first got=%h want=%h", bus.grant, exp_g);
    end
    bus.req_vec[17] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (bus.grant !== exp_g || bus.in_sel !== 15'h0080) begin
        fails++; $display("FAIL hold_cycle%0d got=%h/%h want=%h/%h", c, bus.grant, bus.in_sel, exp_g, 15'h0080);
      end
    end
    bus.req_vec[12] = 1'b0;
    bus.tail_xfer   = 5'b00100;
    tick();
    bus.tail_xfer = '0;
    checks++;
    if (bus.grant !== 25'd0 || bus.out_busy !== 5'd0) begin
      fails++; $display("FAIL hold_release got=%h/%b want=0/0", bus.grant, bus.out_busy);
    end
    tick();
    exp_g = '0; exp_g[13] = 1'b1;
    checks++;
    if (bus.grant !== exp_g || bus.in_sel !== 15'h00C0 || bus.out_busy !== 5'b00100) begin
      fails++; $display("FAIL hold_next got=%h/%h/%b want=%h/%h/%b", bus.grant, bus.in_sel, bus.out_busy, exp_g, 15'h00C0, 5'b00100);
    end
    bus.req_vec = '0;
  endtask

  task automatic test_mask();
    logic [24:0] exp_g;
    do_reset();
    bus.req_vec    = '0;
    bus.req_vec[5] = 1'b1;
    tick();
    exp_g = '0; exp_g[1] = 1'b1;
    checks++;
    if (bus.grant !== exp_g || bus.in_sel !== 15'h0001) begin
      fails++; $display("FAIL mask_first got=%h/%h want=%h/%h", bus.grant, bus.in_sel, exp_g, 15'h0001);
    end
    bus.tail_xfer = 5'b01000;
    tick();
    bus.tail_xfer = '0;
    checks++;
    if (bus.grant !== exp_g || bus.in_granted !== 5'b00010 || bus.out_busy !== 5'b00001) begin
      fails++; $display("FAIL mask_stray got=%h/%b/%b want=%h/%b/%b", bus.grant, bus.in_granted, bus.out_busy, exp_g, 5'b00010, 5'b00001);
    end
    tick();
    checks++;
    if (bus.grant !== exp_g) begin
      fails++; $display("FAIL mask_after got=%h want=%h", bus.grant, exp_g);
    end
    bus.req_vec = '0;
  endtask

  task automatic test_ptr_wrap();
    logic [24:0] exp_g;
    do_reset();
    bus.req_vec     = '0;
    bus.req_vec[19] = 1'b1;
    tick();
    exp_g = '0; exp_g[23] = 1'b1;
    checks++;
    if (bus.grant !== exp_g) begin
      fails++; $display("FAIL wrap_setup got=%h want=%h", bus.grant, exp_g);
    end
    bus.req_vec   = '0;
    bus.tail_xfer = 5'b01000;
    tick();
    bus.tail_xfer   = '0;
    bus.req_vec[4]  = 1'b1;
    bus.req_vec[19] = 1'b1;
    tick();
    exp_g = '0; exp_g[20] = 1'b1;
    checks++;
    if (bus.grant !== exp_g || bus.in_sel !== 15'h0000) begin
      fails++; $display("FAIL wrap_pick0 got=%h/%h want=%h/%h", bus.grant, bus.in_sel, exp_g, 15'h0000);
    end
    bus.tail_xfer = 5'b00001;
    tick();
    bus.tail_xfer = '0;
    tick();
    exp_g = '0; exp_g[23] = 1'b1;
    checks++;
    if (bus.grant !== exp_g || bus.in_sel !== 15'h3000) begin
      fails++; $display("FAIL wrap_ptr1 got=%h/%h want=%h/%h", bus.grant, bus.in_sel, exp_g, 15'h3000);
    end
    bus.req_vec = '0;
  endtask

  task automatic test_parallel();
    logic [24:0] exp_g;
    logic [14:0] exp_s;
    int          o;
    do_reset();
    bus.req_vec = '0;
    exp_g = '0;
    exp_s = '0;
    for (int i = 0; i < 5; i++) begin
      o = (i + 2) % 5;
      bus.req_vec[5*i + o] = 1'b1;
      exp_g[5*o + i]       = 1'b1;
      exp_s[3*o +: 3]      = 3'(i);
    end
    tick();
    checks++;
    if (bus.grant !== exp_g || bus.in_sel !== exp_s) begin
      fails++; $display("FAIL parallel_grant got=%h/%h want=%h/%h", bus.grant, bus.in_sel, exp_g, exp_s);
    end
    checks++;
    if (bus.out_busy !== 5'b11111 || bus.in_granted !== 5'b11111) begin
      fails++; $display("FAIL parallel_flags got=%b/%b want=11111/11111", bus.out_busy, bus.in_granted);
    end
    bus.req_vec = '0;
  endtask

  task automatic test_reset_mid();
    logic [24:0] exp_g;
    do_reset();
    bus.req_vec     = '0;
    bus.req_vec[1]  = 1'b1;
    bus.req_vec[7]  = 1'b1;
    bus.req_vec[13] = 1'b1;
    tick();
    checks++;
    if (bus.out_busy !== 5'b01110) begin
      fails++; $display("FAIL rstmid_locked got=%b want=%b", bus.out_busy, 5'b01110);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.grant !== 25'd0 || bus.in_sel !== 15'd0 || bus.out_busy !== 5'd0 || bus.in_granted !== 5'd0) begin
      fails++; $display("FAIL rstmid_clear got=%h/%h/%b/%b want=0/0/0/0", bus.grant, bus.in_sel, bus.out_busy, bus.in_granted);
    end
    bus.req_vec     = '0;
    bus.req_vec[20] = 1'b1;
    tick();
    exp_g = '0; exp_g[4] = 1'b1;
    checks++;
    if (bus.grant !== exp_g || bus.in_sel !== 15'h0004 || bus.in_granted !== 5'b10000) begin
      fails++; $display("FAIL rstmid_regrant got=%h/%h/%b want=%h/%h/%b", bus.grant, bus.in_sel, bus.in_granted, exp_g, 15'h0004, 5'b10000);
    end
    bus.req_vec = '0;
  endtask

  initial begin
    checks        = 0;
    fails         = 0;
    rst           = 1'b1;
    bus.req_vec   = '0;
    bus.tail_xfer = '0;
    test_reset();
    test_single();
    test_fairness();
    test_lock_hold();
    test_mask();
    test_ptr_wrap();
    test_parallel();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached");
    $fatal(1, "watchdog");
  end
endmodule
